rx_display_scheduler: RTL and testbench

Sequences the read side of the receiver's async FIFO and drives the seven-segment display. It pops one received byte at a time whenever the FIFO is non-empty, classifies it as a hexadecimal ASCII character, and latches valid characters onto the display. Each shown character is held for a programmable dwell time before the next pop, so a burst of UART traffic stays readable. The block sits in the read clock domain, between the async FIFO read port and the `sseg` output of the receiver top level.

---
 rtl/uart_rx_pkg.sv | 65 ++++++
 rtl/hex_ascii_to_sseg.sv | 33 +++
 rtl/rx_display_scheduler.sv | 94 +++++++++
 tb/tb_rx_display_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Purpose: shared types and constants for the UART receive path.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: FSM state enum, hex-ASCII range bounds, seven-segment patterns
// ({g,f,e,d,c,b,a}, active-high), default clock frequency and baud rate.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } rx_state_t;

   localparam int CLK_HZ = 27_000_000;
   localparam int BAUD   = 115200;

   // Inclusive bounds of the accepted hex character ranges
   localparam logic [7:0] ASCII_DIG_LO = 8'h30;  // '0'
   localparam logic [7:0] ASCII_DIG_HI = 8'h39;  // '9'
   localparam logic [7:0] ASCII_UPR_LO = 8'h41;  // 'A'
   localparam logic [7:0] ASCII_UPR_HI = 8'h46;  // 'F'
   localparam logic [7:0] ASCII_LWR_LO = 8'h61;  // 'a'
   localparam logic [7:0] ASCII_LWR_HI = 8'h66;  // 'f'

   localparam logic [6:0] SSEG_0 = 7'b0111111;
   localparam logic [6:0] SSEG_1 = 7'b0000110;
   localparam logic [6:0] SSEG_2 = 7'b1011011;
   localparam logic [6:0] SSEG_3 = 7'b1001111;
   localparam logic [6:0] SSEG_4 = 7'b1100110;
   localparam logic [6:0] SSEG_5 = 7'b1101101;
   localparam logic [6:0] SSEG_6 = 7'b1111101;
   localparam logic [6:0] SSEG_7 = 7'b0000111;
   localparam logic [6:0] SSEG_8 = 7'b1111111;
   localparam logic [6:0] SSEG_9 = 7'b1101111;
   localparam logic [6:0] SSEG_A = 7'b1110111;
   localparam logic [6:0] SSEG_B = 7'b1111100;
   localparam logic [6:0] SSEG_C = 7'b0111001;
   localparam logic [6:0] SSEG_D = 7'b1011110;
   localparam logic [6:0] SSEG_E = 7'b1111001;
   localparam logic [6:0] SSEG_F = 7'b1110001;

   function automatic logic [6:0] sseg_of(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = SSEG_0;
         4'h1:    pat = SSEG_1;
         4'h2:    pat = SSEG_2;
         4'h3:    pat = SSEG_3;
         4'h4:    pat = SSEG_4;
         4'h5:    pat = SSEG_5;
         4'h6:    pat = SSEG_6;
         4'h7:    pat = SSEG_7;
         4'h8:    pat = SSEG_8;
         4'h9:    pat = SSEG_9;
         4'hA:    pat = SSEG_A;
         4'hB:    pat = SSEG_B;
         4'hC:    pat = SSEG_C;
         4'hD:    pat = SSEG_D;
         4'hE:    pat = SSEG_E;
         default: pat = SSEG_F;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/hex_ascii_to_sseg.sv
// Purpose: classify one ASCII byte as a hex digit and map it to a segment pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
// Ports: ascii (8b in), pattern (7b {g,f,e,d,c,b,a} out), valid (1b out, byte is 0-9/A-F/a-f).
module hex_ascii_to_sseg
   import uart_rx_pkg::*;
(
   input  logic [7:0] ascii,
   output logic [6:0] pattern,
   output logic       valid
);

   logic       is_dig;
   logic       is_upr;
   logic       is_lwr;
   logic [3:0] nib;

   always_comb begin
      is_dig = (ascii >= ASCII_DIG_LO) && (ascii <= ASCII_DIG_HI);
      is_upr = (ascii >= ASCII_UPR_LO) && (ascii <= ASCII_UPR_HI);
      is_lwr = (ascii >= ASCII_LWR_LO) && (ascii <= ASCII_LWR_HI);
      nib    = 4'h0;
      if (is_dig) begin
         nib = ascii[3:0];
      end else if (is_upr || is_lwr) begin
         // 'A'/'a' have low nibble 1, so adding 9 lands on 0xA
         nib = ascii[3:0] + 4'd9;
      end
      valid   = is_dig || is_upr || is_lwr;
      pattern = sseg_of(nib);
   end

endmodule

// File: rtl/rx_display_scheduler.sv
// Purpose: pops received bytes from the async FIFO and shows hex characters on the 7-seg display.
// Latency: pop in cycle N, byte sampled in N+1, sseg updated from N+2; valid chars then dwell DWELL_CYCLES.
// Backpressure: pops only in IDLE while FIFO non-empty; fifo_empty ignored during READ/HOLD.
// Ports: clk, rst (sync, active-high), fifo_empty, fifo_rd_data[7:0] in;
//        fifo_rd_en, sseg[6:0], digit_valid, hold_busy, bad_char_cnt[7:0] out.
module rx_display_scheduler
   import uart_rx_pkg::*;
#(
   parameter int DWELL_CYCLES = 27_000_000,
   parameter int CNT_W        = 25
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   output logic       fifo_rd_en,
   output logic [6:0] sseg,
   output logic       digit_valid,
   output logic       hold_busy,
   output logic [7:0] bad_char_cnt
);

   localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

   rx_state_t        state;
   rx_state_t        state_nxt;
   logic [CNT_W-1:0] dwell_cnt;
   logic [6:0]       dec_pattern;
   logic             dec_valid;

   hex_ascii_to_sseg u_dec (
      .ascii   (fifo_rd_data),
      .pattern (dec_pattern),
      .valid   (dec_valid)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = READ;
         READ:    state_nxt = dec_valid ? HOLD : IDLE;
         HOLD:    if (dwell_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs; the rst term keeps a pop from escaping during the reset cycle
   always_comb begin
      fifo_rd_en = 1'b0;
      hold_busy  = 1'b0;
      case (state)
         IDLE:    fifo_rd_en = !fifo_empty && !rst;
         HOLD:    hold_busy  = 1'b1;
         default: ;
      endcase
   end

   // Display, dwell counter and reject counter
   always_ff @(posedge clk) begin
      if (rst) begin
         sseg         <= '0;
         digit_valid  <= 1'b0;
         dwell_cnt    <= '0;
         bad_char_cnt <= '0;
      end else begin
         case (state)
            READ: begin
               if (dec_valid) begin
                  sseg        <= dec_pattern;
                  digit_valid <= 1'b1;
                  dwell_cnt   <= DWELL_LOAD;
               end else if (bad_char_cnt != 8'hFF) begin
                  bad_char_cnt <= bad_char_cnt + 8'd1;
               end
            end
            HOLD: begin
               if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_display_scheduler.sv
// Purpose: directed self-checking bench for rx_display_scheduler with DWELL_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_display_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_en;
   logic [6:0] sseg;
   logic       digit_valid;
   logic       hold_busy;
   logic [7:0] bad_char_cnt;

   rx_display_scheduler #(
      .DWELL_CYCLES (4),
      .CNT_W        (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .sseg         (sseg),
      .digit_valid  (digit_valid),
      .hold_busy    (hold_busy),
      .bad_char_cnt (bad_char_cnt)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int last_pop_cyc = 0;
   int hb_cnt = 0;
   int hold_pop_err = 0;
   logic [7:0] q[$];

   always @(posedge clk) cyc++;

   // FIFO model: samples the pop strobe just before the edge, presents data after it
   always begin
      logic do_pop;
      @(negedge clk);
      #4;
      do_pop = fifo_rd_en;
      if (fifo_rd_en) begin
         pop_cnt++;
         last_pop_cyc = cyc;
         if (hold_busy) hold_pop_err++;
      end
      if (hold_busy) hb_cnt++;
      @(posedge clk);
      #1;
      if (do_pop && q.size() > 0) fifo_rd_data = q.pop_front();
      fifo_empty = (q.size() == 0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Returns at the negedge of the cycle after the pop (the READ cycle)
   task automatic wait_pop();
      int pc;
      bit seen;
      pc = pop_cnt;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (pop_cnt != pc) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("pop_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (q.size() == 0 && fifo_empty && !hold_busy && !fifo_rd_en) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      repeat (3) step();
   endtask

   logic [7:0] vec_ascii [8];
   logic [6:0] vec_sseg  [8];

   initial begin
      int c1;
      int c2;
      int hb0;
      int pc;
      int rel_cyc;

      vec_ascii[0] = 8'h30; vec_sseg[0] = 7'b0111111;
      vec_ascii[1] = 8'h39; vec_sseg[1] = 7'b1101111;
      vec_ascii[2] = 8'h41; vec_sseg[2] = 7'b1110111;
      vec_ascii[3] = 8'h46; vec_sseg[3] = 7'b1110001;
      vec_ascii[4] = 8'h61; vec_sseg[4] = 7'b1110111;
      vec_ascii[5] = 8'h66; vec_sseg[5] = 7'b1110001;
      vec_ascii[6] = 8'h62; vec_sseg[6] = 7'b1111100;
      vec_ascii[7] = 8'h43; vec_sseg[7] = 7'b0111001;

      // Reset held 3 cycles with a byte waiting
      q.push_back(8'h35);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
         chk("rst_sseg", 32'(sseg), 32'd0);
         chk("rst_bad", 32'(bad_char_cnt), 32'd0);
         chk("rst_dv", 32'(digit_valid), 32'd0);
         chk("rst_hold", 32'(hold_busy), 32'd0);
      end
      chk("rst_fifo_nonempty", 32'(fifo_empty), 32'd0);
      chk("rst_no_pop", 32'(pop_cnt), 32'd0);

      // Single valid byte 0x35
      hb0 = hb_cnt;
      rst = 1'b0;
      wait_pop();
      chk("single_pulse", 32'(fifo_rd_en), 32'd0);
      chk("single_dv_pre", 32'(digit_valid), 32'd0);
      step();
      chk("single_sseg", 32'(sseg), 32'(7'b1101101));
      chk("single_dv", 32'(digit_valid), 32'd1);
      chk("single_hold", 32'(hold_busy), 32'd1);
      wait_drain();
      chk("single_hold_len", 32'(hb_cnt - hb0), 32'd4);
      chk("single_pops", 32'(pop_cnt), 32'd1);

      // Burst 0x35, 0x38
      q.push_back(8'h35);
      q.push_back(8'h38);
      wait_pop();
      c1 = last_pop_cyc;
      step();
      chk("burst_sseg0", 32'(sseg), 32'(7'b1101101));
      wait_pop();
      c2 = last_pop_cyc;
      chk("burst_spacing", 32'(c2 - c1), 32'd6);
      step();
      chk("burst_sseg1", 32'(sseg), 32'(7'b1111111));
      wait_drain();

      // Invalid bytes 'Z', LF
      q.push_back(8'h5A);
      q.push_back(8'h0A);
      wait_pop();
      c1 = last_pop_cyc;
      wait_pop();
      c2 = last_pop_cyc;
      chk("inv_spacing", 32'(c2 - c1), 32'd2);
      wait_drain();
      chk("inv_bad", 32'(bad_char_cnt), 32'd2);
      chk("inv_sseg_kept", 32'(sseg), 32'(7'b1111111));

      // Range edges just outside each accepted band
      q.push_back(8'h2F); q.push_back(8'h3A); q.push_back(8'h40);
      q.push_back(8'h47); q.push_back(8'h60); q.push_back(8'h67);
      wait_drain();
      chk("edge_bad", 32'(bad_char_cnt), 32'd8);
      chk("edge_sseg_kept", 32'(sseg), 32'(7'b1111111));

      // Valid range edges and mixed case
      for (int i = 0; i < 8; i++) begin
         q.push_back(vec_ascii[i]);
         wait_pop();
         step();
         chk($sformatf("dec_%02h", vec_ascii[i]), 32'(sseg), 32'(vec_sseg[i]));
         wait_drain();
      end

      // Saturation: 300 rejected bytes
      for (int i = 0; i < 300; i++) q.push_back(8'h00);
      wait_drain();
      chk("sat_bad", 32'(bad_char_cnt), 32'd255);
      chk("sat_sseg_kept", 32'(sseg), 32'(7'b0111001));
      chk("sat_dv", 32'(digit_valid), 32'd1);

      // Reset for one cycle during HOLD
      q.push_back(8'h37);
      wait_pop();
      step();
      chk("mid_sseg", 32'(sseg), 32'(7'b0000111));
      chk("mid_hold", 32'(hold_busy), 32'd1);
      q.push_back(8'h31);
      pc = pop_cnt;
      rst = 1'b1;
      step();
      chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("mid_rst_sseg", 32'(sseg), 32'd0);
      chk("mid_rst_hold", 32'(hold_busy), 32'd0);
      chk("mid_rst_dv", 32'(digit_valid), 32'd0);
      chk("mid_rst_bad", 32'(bad_char_cnt), 32'd0);
      rel_cyc = cyc;
      rst = 1'b0;
      wait_pop();
      chk("mid_pops_total", 32'(pop_cnt - pc), 32'd1);
      chk("mid_pop_after_rel", 32'(last_pop_cyc), 32'(rel_cyc));
      step();
      chk("mid_sseg_new", 32'(sseg), 32'(7'b0000110));
      wait_drain();

      chk("no_pop_in_hold", 32'(hold_pop_err), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
